// File: rtl/libv_pkg.sv
// libv_pkg: shared deque command encoding and op classification helpers
package libv_pkg;
    typedef enum logic [1:0] {
        OpPushFront = 2'b00,
        OpPopFront  = 2'b01,
        OpPushBack  = 2'b10,
        OpPopBack   = 2'b11
    } deque_op_t;
    function automatic logic is_push(deque_op_t op);
        return ~op[0];
    endfunction
    function automatic logic is_pop(deque_op_t op);
        return op[0];
    endfunction
endpackage

// File: rtl/rr_arb.sv
// rr_arb: pointer-based round-robin arbiter; lowest offset from ptr wins, ptr moves past the winner on adv
module rr_arb #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    logic [PW-1:0] ptr;
    logic [PW-1:0] nextPtr;
    logic [PW-1:0] idx;
    logic [PW:0]   sum;
    always_comb begin
        gnt = '0;
        nextPtr = ptr;
        idx = '0;
        sum = '0;
        // scan from the far end so the closest requester to ptr is written last
        for (int i = N - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (PW + 1)'(i);
            idx = PW'((sum >= (PW + 1)'(N)) ? sum - (PW + 1)'(N) : sum);
            if (req[idx]) begin
                gnt = '0;
                gnt[idx] = 1'b1;
                nextPtr = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (adv)
            ptr <= nextPtr;
    end
endmodule

// File: rtl/deque_cmd_arb.sv
// deque_cmd_arb: round-robin issue of requester commands to one deque with occupancy guarding and pop routing
module deque_cmd_arb
    import libv_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_vld,
    input  logic [2*N_REQ-1:0]         req_op,
    input  logic [W*N_REQ-1:0]         req_dat,
    output logic [N_REQ-1:0]           req_gnt,
    output logic [N_REQ-1:0]           rsp_vld,
    output logic [W-1:0]               rsp_dat,
    output logic                       dq_vld,
    output logic [1:0]                 dq_op,
    output logic [W-1:0]               dq_dat,
    input  logic [W-1:0]               dq_pop_dat,
    output logic [$clog2(DEPTH+1)-1:0] occ,
    output logic                       empty,
    output logic                       full
);
    localparam int OW = $clog2(DEPTH + 1);
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] popOwner;
    logic             pushIssue;
    logic             popIssue;
    // nothing issues while rst is high, so a pop in the reset cycle never reaches the deque
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++)
            eligible[i] = !rst && req_vld[i] &&
                (is_push(deque_op_t'(req_op[2*i+:2])) ? !full : !empty);
    end
    rr_arb #(.N(N_REQ)) uArb (
        .clk (clk),
        .rst (rst),
        .req (eligible),
        .adv (dq_vld),
        .gnt (req_gnt)
    );
    always_comb begin
        dq_op = '0;
        dq_dat = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_gnt[i]) begin
                dq_op = req_op[2*i+:2];
                dq_dat = req_dat[W*i+:W];
            end
        end
    end
    assign dq_vld    = |req_gnt;
    assign pushIssue = dq_vld && is_push(deque_op_t'(dq_op));
    assign popIssue  = dq_vld && is_pop(deque_op_t'(dq_op));
    assign empty     = occ == '0;
    assign full      = occ == OW'(DEPTH);
    assign rsp_vld   = popOwner;
    assign rsp_dat   = dq_pop_dat;
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
            popOwner <= '0;
        end else begin
            occ <= occ + OW'(pushIssue) - OW'(popIssue);
            popOwner <= popIssue ? req_gnt : '0;
        end
    end
    assert property (@(posedge clk) disable iff (rst) $onehot0(req_gnt));
    assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_vld));
    assert property (@(posedge clk) disable iff (rst) occ <= OW'(DEPTH));
    assert property (@(posedge clk) disable iff (rst) !(dq_vld && is_pop(deque_op_t'(dq_op)) && empty));
endmodule
